// File: rtl/hft_pkg.sv
// Shared types for the HFT transmit path: record layout,
// default widths and the transmit arbiter states.
package hft_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int TS_W_DEF   = 32;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] buysell;
        logic [TS_W_DEF-1:0]   timestamp;
    } tx_record_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        WAIT_FALL
    } arb_state_t;

endpackage

// File: rtl/tx_ch_fifo.sv
// Per-channel record FIFO: DEPTH entries, registered full flag,
// one-cycle drop pulse when a write hits a full FIFO that is not popped.
module tx_ch_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic         drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          drop_q, drop_d;
    logic          wr_en, rd_en;
    logic [W-1:0]  mem_q [DEPTH];

    // A pop in the same cycle frees the slot the push lands in
    always_comb begin
        rd_en    = pop && (count_q != '0);
        wr_en    = push && (!full_q || rd_en);
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        full_d   = (count_d == FULL_CNT);
        drop_d   = push && !wr_en;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = (count_q == '0);
    assign drop  = drop_q;

endmodule

// File: rtl/tx_arb_mux_n.sv
// N-channel transmit mux: per-channel FIFOs, round-robin grant,
// one UART launch per frame with the address derived from the channel.
module tx_arb_mux_n
    import hft_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DEPTH     = 2,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int TS_W      = TS_W_DEF,
    parameter int BASE_ADDR = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH*ADDR_W-1:0] tx_buysell_in,
    input  logic [NUM_CH*TS_W-1:0]   tx_timestamp_in,
    input  logic [NUM_CH-1:0]        tx_dv_in,
    output logic [NUM_CH-1:0]        ch_full,
    output logic [NUM_CH-1:0]        ch_drop,
    output logic [ADDR_W-1:0]        tx_addr,
    output logic [ADDR_W-1:0]        tx_buysell,
    output logic [TS_W-1:0]          tx_timestamp,
    output logic                     tx_dv,
    input  logic                     tx_busy
);

    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int RW = ADDR_W + TS_W;

    logic [RW-1:0]     head [NUM_CH];
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] pop_vec;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tx_ch_fifo #(
            .W     (RW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (tx_dv_in[i]),
            .pop     (pop_vec[i]),
            .din     ({tx_buysell_in[i*ADDR_W +: ADDR_W],
                       tx_timestamp_in[i*TS_W +: TS_W]}),
            .dout    (head[i]),
            .full    (ch_full[i]),
            .empty   (empty[i]),
            .drop    (ch_drop[i])
        );
    end

    arb_state_t        state_q, state_d;
    logic [CW-1:0]     last_q, last_d;
    logic              dv_q, dv_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] bs_q, bs_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [CW-1:0]     grant, idx;
    logic              found;

    // First non-empty channel after the last grant, wrapping
    always_comb begin
        found = 1'b0;
        grant = last_q;
        idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = CW'((int'(last_q) + k) % NUM_CH);
            if (!found && !empty[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        dv_d    = 1'b0;
        addr_d  = addr_q;
        bs_d    = bs_q;
        ts_d    = ts_q;
        pop_vec = '0;
        unique case (state_q)
            IDLE: begin
                if (!tx_busy && found) begin
                    dv_d           = 1'b1;
                    pop_vec[grant] = 1'b1;
                    addr_d         = ADDR_W'(BASE_ADDR) + ADDR_W'(grant);
                    {bs_d, ts_d}   = head[grant];
                    last_d         = grant;
                    state_d        = WAIT_RISE;
                end
            end
            WAIT_RISE: state_d = WAIT_FALL;
            WAIT_FALL: if (!tx_busy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= CW'(NUM_CH - 1);
            dv_q    <= 1'b0;
            addr_q  <= '0;
            bs_q    <= '0;
            ts_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            dv_q    <= dv_d;
            addr_q  <= addr_d;
            bs_q    <= bs_d;
            ts_q    <= ts_d;
        end
    end

    assign tx_dv        = dv_q;
    assign tx_addr      = addr_q;
    assign tx_buysell   = bs_q;
    assign tx_timestamp = ts_q;

endmodule

// File: doc/tx_arb_mux_n.md
Name: tx_arb_mux_n

Overview:
N-channel successor of the single-system transmit mux. It collects buy/sell decisions from NUM_CH strategy systems, buffers each channel in its own small FIFO, and arbitrates round-robin onto the single UART transmit interface. It sits between the system instances and the uart block. The UART address byte is generated from the channel index, so systems no longer drive it.

Parameters:
NUM_CH, 4, number of system channels (1..16)
DEPTH, 2, entries per channel FIFO (power of 2, >=2)
ADDR_W, 8, width of tx_addr and tx_buysell
TS_W, 32, width of tx_timestamp
BASE_ADDR, 0, tx_addr value for channel 0; channel i sends BASE_ADDR+i (mod 2^ADDR_W)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
tx_buysell_in  in  NUM_CH*ADDR_W  per-channel decision; channel i at bits [i*ADDR_W +: ADDR_W]
tx_timestamp_in  in  NUM_CH*TS_W  per-channel timestamp, same packing
tx_dv_in  in  NUM_CH  per-channel write strobe, one cycle per record
ch_full  out  NUM_CH  channel FIFO full (registered)
ch_drop  out  NUM_CH  one-cycle pulse: write to channel was discarded
tx_addr  out  ADDR_W  to uart: record address
tx_buysell  out  ADDR_W  to uart: decision
tx_timestamp  out  TS_W  to uart: timestamp
tx_dv  out  1  to uart: one-cycle launch strobe
tx_busy  in  1  from uart: high while a frame is being sent

Behaviour:
- Reset (async assert, sync release): all FIFOs empty, ch_full=0, ch_drop=0, tx_dv=0, tx_addr/tx_buysell/tx_timestamp=0, state IDLE, last_grant=NUM_CH-1 (channel 0 wins first). Reset mid-frame discards all buffered and in-flight records; no tx_dv is issued.
- Push: tx_dv_in[i]=1 and FIFO i not full -> record written that cycle. If full and not popped the same cycle -> record dropped, ch_drop[i]=1 next cycle, FIFO unchanged. If full and popped the same cycle -> push is accepted and count is unchanged.
- ch_full[i] reflects the post-update count (count==DEPTH) and is registered.
- UART contract: uart accepts tx_dv only when tx_busy=0, then raises tx_busy in the next cycle and holds it until the frame completes.
- FSM:
  - IDLE: if tx_busy=0 and any FIFO is non-empty, grant the first non-empty channel searching from (last_grant+1) mod NUM_CH upward with wrap. Register its head record plus tx_addr=BASE_ADDR+grant. Pulse tx_dv=1 for exactly one cycle. Pop that FIFO. Set last_grant=grant. -> WAIT_RISE. Otherwise stay.
  - WAIT_RISE: exactly one cycle, ignoring tx_busy -> WAIT_FALL.
  - WAIT_FALL: stay while tx_busy=1. On tx_busy=0 -> IDLE.
- Latency: a record written into an empty FIFO with the FSM in IDLE and tx_busy=0 produces tx_dv 2 cycles after tx_dv_in (1 cycle write, 1 cycle launch).
- Minimum spacing between tx_dv pulses is 3 cycles, even if tx_busy never asserts.
- Data outputs hold their value until the next launch.
- A push to the granted channel in the pop cycle is legal; FIFO ordering is strictly preserved.
- NUM_CH=1 degenerates to a buffered pass-through with the same FSM.

Decomposition:
- Shared package hft_pkg: ADDR_W/TS_W defaults, tx_record struct (buysell, timestamp), arbiter state enum (IDLE, WAIT_RISE, WAIT_FALL).
- One sub-module tx_ch_fifo: DEPTH-entry synchronous FIFO with push/pop/full/empty and pointer wrap.
- Instantiated NUM_CH times via generate; the arbiter and FSM live in the top.

Test Plan:
- Single record: ch1 writes buysell=0x01, ts=0x0000_1234, BASE_ADDR=0x10, tx_busy=0 -> tx_dv 2 cycles later with tx_addr=0x11, buysell=0x01, ts=0x1234; no second pulse.
- Round-robin: ch0, ch2, ch3 write in the same cycle, uart holds busy 10 cycles per frame -> launch order ch0, ch2, ch3. Then ch0 and ch3 write together -> ch0 first (last_grant=3 wraps to 0).
- Overflow: DEPTH=2, tx_busy held high, ch0 writes 3 records -> ch_full[0]=1 after the 2nd write, ch_drop[0] pulses once after the 3rd; after busy drops, exactly 2 records are sent, in order.
- Full with simultaneous pop: ch0 full, write coincides with the launch pop -> no ch_drop; 3 records total emerge in order.
- Busy gating: tx_busy stuck high with data pending -> no tx_dv. Release -> tx_dv one cycle after the FSM sees busy low in IDLE.
- Reset mid-frame: assert reset_n=0 in WAIT_FALL with 2 records queued -> all outputs 0 immediately. After release, no tx_dv until new writes arrive.
